// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI controller between N_REQ requesters, with per-requester chip-select demux.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort transactions that run longer than TIMEOUT_CYCLES.
module spi_request_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req_valid,
    output logic [N_REQ-1:0]     o_req_ready,
    input  logic [32*N_REQ-1:0]  i_req_din,
    input  logic [8*N_REQ-1:0]   i_req_mosi_width,
    input  logic [8*N_REQ-1:0]   i_req_miso_width,
    input  logic [2*N_REQ-1:0]   i_req_mode,
    output logic [N_REQ-1:0]     o_resp_valid,
    output logic [31:0]          o_resp_data,
    output logic                 o_resp_err,
    output logic                 o_spi_kick,
    output logic [31:0]          o_spi_din,
    output logic [7:0]           o_spi_mosi_width,
    output logic [7:0]           o_spi_miso_width,
    output logic                 o_spi_cpol,
    output logic                 o_spi_cpha,
    input  logic                 i_spi_busy,
    input  logic [31:0]          i_spi_dout,
    input  logic                 i_spi_cs,
    output logic [N_REQ-1:0]     o_cs_n,
    output logic                 o_arb_busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESPOND,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IW-1:0]     r_grant_idx;
    logic [IW-1:0]     r_last_grant;
    logic [IW-1:0]     w_grant_idx;
    logic [IW-1:0]     w_cand;
    logic              w_found;
    logic              w_any_req;
    logic              w_timeout;
    logic              w_enter_launch;
    logic              w_enter_respond;
    logic [N_REQ-1:0]  r_req_ready;
    logic [N_REQ-1:0]  r_resp_valid;
    logic [31:0]       r_resp_data;
    logic [31:0]       r_spi_din;
    logic [7:0]        r_spi_mosi_width;
    logic [7:0]        r_spi_miso_width;
    logic [1:0]        r_spi_mode;

    assign w_any_req = |i_req_valid;

    // Search starts one past the previous winner so every requester is reached within N_REQ grants.
    always_comb begin
        w_grant_idx = r_last_grant;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IW'((int'(r_last_grant) + k) % N_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_grant_idx = w_cand;
                w_found     = 1'b1;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_timeout_cnt;
    logic        r_resp_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_timeout_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_timeout_cnt <= '0;
        end else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) &&
                       (r_timeout_cnt == TIMEOUT_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_any_req) w_state_next = S_LAUNCH;
            S_LAUNCH:    w_state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (i_spi_busy) w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!i_spi_busy) w_state_next = S_RESPOND;
            S_RESPOND:   w_state_next = S_GAP;
            S_GAP:       w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_RESPOND;
        end
    end

    // KICK spans LAUNCH and WAIT_BUSY only, so RESPOND/GAP/IDLE give it a low run before each rise.
    always_comb begin
        o_spi_kick = (r_state == S_LAUNCH) || (r_state == S_WAIT_BUSY);
        o_arb_busy = (r_state != S_IDLE);
    end

    assign w_enter_launch  = (r_state == S_IDLE) && (w_state_next == S_LAUNCH);
    assign w_enter_respond = (r_state != S_RESPOND) && (w_state_next == S_RESPOND);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_grant_idx      <= '0;
            r_last_grant     <= IW'(N_REQ - 1);
            r_req_ready      <= '0;
            r_resp_valid     <= '0;
            r_resp_data      <= '0;
            r_spi_din        <= '0;
            r_spi_mosi_width <= '0;
            r_spi_miso_width <= '0;
            r_spi_mode       <= '0;
        end else begin
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            if (w_enter_launch) begin
                r_grant_idx      <= w_grant_idx;
                r_last_grant     <= w_grant_idx;
                r_req_ready      <= ONE_HOT0 << w_grant_idx;
                r_spi_din        <= i_req_din[32*w_grant_idx +: 32];
                r_spi_mosi_width <= i_req_mosi_width[8*w_grant_idx +: 8];
                r_spi_miso_width <= i_req_miso_width[8*w_grant_idx +: 8];
                r_spi_mode       <= i_req_mode[2*w_grant_idx +: 2];
            end
            if (w_enter_respond) begin
                r_resp_valid <= ONE_HOT0 << r_grant_idx;
                r_resp_data  <= w_timeout ? 32'd0 : i_spi_dout;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_resp_err <= 1'b0;
        end else if (w_enter_respond) begin
            r_resp_err <= w_timeout;
        end
    end
    assign o_resp_err = r_resp_err;
`else
    assign o_resp_err = 1'b0;
`endif

    assign o_req_ready      = r_req_ready;
    assign o_resp_valid     = r_resp_valid;
    assign o_resp_data      = r_resp_data;
    assign o_spi_din        = r_spi_din;
    assign o_spi_mosi_width = r_spi_mosi_width;
    assign o_spi_miso_width = r_spi_miso_width;
    assign o_spi_cpol       = r_spi_mode[1];
    assign o_spi_cpha       = r_spi_mode[0];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cs_demux
            assign o_cs_n[gi] = ((r_state != S_IDLE) && (r_grant_idx == IW'(gi))) ? i_spi_cs : 1'b1;
        end
    endgenerate

endmodule
